// File: rtl/icache_if.sv
// Fetcher / memCtrl / ROB-flush signal bundle for the instruction cache.
// slave is the cache side; master is the environment (fetcher + memCtrl + ROB).
interface icache_if;
  logic        in_fetcher_flag;
  logic [31:0] in_fetcher_pc;
  logic        out_fetcher_flag;
  logic [31:0] out_fetcher_inst;
  logic        out_mem_flag;
  logic [31:0] out_mem_addr;
  logic        in_mem_flag;
  logic [31:0] in_mem_data;
  logic        in_rob_xbp;

  modport slave (
    input  in_fetcher_flag, in_fetcher_pc, in_mem_flag, in_mem_data, in_rob_xbp,
    output out_fetcher_flag, out_fetcher_inst, out_mem_flag, out_mem_addr
  );

  modport master (
    output in_fetcher_flag, in_fetcher_pc, in_mem_flag, in_mem_data, in_rob_xbp,
    input  out_fetcher_flag, out_fetcher_inst, out_mem_flag, out_mem_addr
  );
endinterface

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache; refills 4-word lines one word at a time
// from memCtrl and abandons an in-flight refill on a mispredict flush.
module icache #(
  parameter int unsigned INDEX_BITS     = 6,
  parameter int unsigned LINE_WORDS_LOG = 2
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     rdy,
  icache_if.slave  bus
);

  localparam int unsigned OFF_BITS  = LINE_WORDS_LOG + 2;
  localparam int unsigned TAG_BITS  = 32 - OFF_BITS - INDEX_BITS;
  localparam int unsigned LINES     = 1 << INDEX_BITS;
  localparam int unsigned WORDS     = 1 << LINE_WORDS_LOG;
  localparam int unsigned SLOT_BITS = INDEX_BITS + LINE_WORDS_LOG;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] REFILL = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  logic [1:0]                state, state_d;
  logic [LINE_WORDS_LOG-1:0] cnt, cnt_d, cnt_inc;
  logic [31:2]               pc_q, pc_d;
  logic                      fflag_d, mflag_d;
  logic [31:0]               finst_d, maddr_d;
  logic                      wr_en, valid_set, valid_clr;

  logic [LINES-1:0]          valid;
  logic [TAG_BITS-1:0]       tag_mem  [LINES];
  logic [31:0]               data_mem [LINES*WORDS];

  logic [INDEX_BITS-1:0]     req_idx, lat_idx;
  logic [TAG_BITS-1:0]       req_tag, lat_tag;
  logic [LINE_WORDS_LOG-1:0] req_off, lat_off;
  logic [SLOT_BITS-1:0]      req_slot, lat_slot, wr_slot;
  logic                      hit_c, take_c;
  logic                      unused_pc_bits;

  // Address split for the incoming request and for the latched (refilling) request.
  assign req_idx  = bus.in_fetcher_pc[OFF_BITS +: INDEX_BITS];
  assign req_tag  = bus.in_fetcher_pc[31 -: TAG_BITS];
  assign req_off  = bus.in_fetcher_pc[2 +: LINE_WORDS_LOG];
  assign lat_idx  = pc_q[OFF_BITS +: INDEX_BITS];
  assign lat_tag  = pc_q[31 -: TAG_BITS];
  assign lat_off  = pc_q[2 +: LINE_WORDS_LOG];
  assign req_slot = {req_idx, req_off};
  assign lat_slot = {lat_idx, lat_off};
  assign wr_slot  = {lat_idx, cnt};
  assign unused_pc_bits = ^bus.in_fetcher_pc[1:0];

  assign hit_c   = valid[req_idx] && (tag_mem[req_idx] == req_tag);
  // A memCtrl pulse only counts while our word request is actually up.
  assign take_c  = bus.in_mem_flag && bus.out_mem_flag;
  assign cnt_inc = cnt + LINE_WORDS_LOG'(1);

  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    pc_d      = pc_q;
    fflag_d   = 1'b0;
    finst_d   = bus.out_fetcher_inst;
    mflag_d   = bus.out_mem_flag;
    maddr_d   = bus.out_mem_addr;
    wr_en     = 1'b0;
    valid_set = 1'b0;
    valid_clr = 1'b0;

    if (bus.in_rob_xbp) begin
      state_d = IDLE;
      mflag_d = 1'b0;
      cnt_d   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_fetcher_flag && !bus.out_fetcher_flag) begin
            pc_d = bus.in_fetcher_pc[31:2];
            if (hit_c) begin
              fflag_d = 1'b1;
              finst_d = data_mem[req_slot];
            end else begin
              state_d   = REFILL;
              cnt_d     = '0;
              mflag_d   = 1'b1;
              maddr_d   = {bus.in_fetcher_pc[31:OFF_BITS], OFF_BITS'(0)};
              valid_clr = 1'b1;
            end
          end
        end
        REFILL: begin
          if (!bus.out_mem_flag) begin
            // One-cycle gap between words is over; raise the next request.
            mflag_d = 1'b1;
          end else if (take_c) begin
            wr_en   = 1'b1;
            mflag_d = 1'b0;
            if (cnt != '1) begin
              cnt_d   = cnt_inc;
              maddr_d = {pc_q[31:OFF_BITS], cnt_inc, 2'b00};
            end else begin
              valid_set = 1'b1;
              state_d   = RESP;
              cnt_d     = '0;
              fflag_d   = 1'b1;
              finst_d   = (lat_off == cnt) ? bus.in_mem_data : data_mem[lat_slot];
            end
          end
        end
        RESP:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Control state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state                <= IDLE;
      cnt                  <= '0;
      pc_q                 <= '0;
      valid                <= '0;
      bus.out_fetcher_flag <= 1'b0;
      bus.out_fetcher_inst <= '0;
      bus.out_mem_flag     <= 1'b0;
      bus.out_mem_addr     <= '0;
    end else if (rdy) begin
      state                <= state_d;
      cnt                  <= cnt_d;
      pc_q                 <= pc_d;
      bus.out_fetcher_flag <= fflag_d;
      bus.out_fetcher_inst <= finst_d;
      bus.out_mem_flag     <= mflag_d;
      bus.out_mem_addr     <= maddr_d;
      if (valid_clr) valid[req_idx] <= 1'b0;
      if (valid_set) valid[lat_idx] <= 1'b1;
    end
  end

  // Tag and data arrays carry no reset; the valid bits guard them.
  always_ff @(posedge clk) begin
    if (!rst && rdy) begin
      if (wr_en)     data_mem[wr_slot] <= bus.in_mem_data;
      if (valid_set) tag_mem[lat_idx]  <= lat_tag;
    end
  end

endmodule

// File: tb/tb_icache.sv
// Scoreboarded bench for icache: a line-level cache model predicts responses and
// refill addresses; a latency-2 memCtrl model serves refills and honours rdy/flush/reset.
module tb_icache;

  logic clk = 1'b0;
  logic rst;
  logic rdy;

  icache_if bus ();

  icache dut (
    .clk (clk),
    .rst (rst),
    .rdy (rdy),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned passes = 0;

  logic [31:0] exp_inst [$];
  logic [31:0] exp_addr [$];

  bit          vm [64];
  logic [21:0] tm [64];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got=%h expected=%h at %0t", name, got, exp, $time);
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a >= 32'h100 && a < 32'h110) return 32'h11 * ((a - 32'h100) / 32'd4 + 32'd1);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Response monitor: one pop per pulse, counted on the cycle it is consumed.
  logic [31:0] mon_exp;
  always @(negedge clk) begin
    if (!rst && rdy && bus.out_fetcher_flag) begin
      check("resp_pending", 32'(exp_inst.size() != 0), 32'd1);
      if (exp_inst.size() != 0) begin
        mon_exp = exp_inst.pop_front();
        check("resp_inst", bus.out_fetcher_inst, mon_exp);
      end
    end
  end

  // memCtrl model: sees a request, answers LAT live cycles later, frozen by rdy.
  localparam int LAT = 2;
  localparam int M_IDLE = 0, M_WAIT = 1, M_PULSE = 2;
  int          ms = M_IDLE;
  int          lat = 0;
  logic [31:0] cur_addr = '0;
  bit          last_rst = 1'b1, last_rdy = 1'b0, last_xbp = 1'b0;

  always @(negedge clk) begin
    if (last_rst) begin
      ms = M_IDLE;
      bus.in_mem_flag = 1'b0;
      bus.in_mem_data = '0;
    end else if (last_rdy) begin
      if (last_xbp) begin
        ms = M_IDLE;
        bus.in_mem_flag = 1'b0;
      end else begin
        case (ms)
          M_IDLE: if (bus.out_mem_flag) begin
            check("mem_req_expected", 32'(exp_addr.size() != 0), 32'd1);
            if (exp_addr.size() != 0) check("mem_addr", bus.out_mem_addr, exp_addr.pop_front());
            cur_addr = bus.out_mem_addr;
            lat = LAT;
            ms = M_WAIT;
          end
          M_WAIT: begin
            lat--;
            if (lat == 0) begin
              bus.in_mem_flag = 1'b1;
              bus.in_mem_data = mem_word(cur_addr);
              ms = M_PULSE;
            end
          end
          default: begin
            bus.in_mem_flag = 1'b0;
            ms = M_IDLE;
          end
        endcase
      end
    end
    last_rst = rst;
    last_rdy = rdy;
    last_xbp = bus.in_rob_xbp;
  end

  // stall_at: -1 none, -2 random rdy drops, >=0 drop rdy for 3 cycles after that many edges.
  task automatic fetch(input logic [31:0] pc, input int stall_at, output int cycles);
    logic [5:0]  idx;
    logic [21:0] tg;
    bit          seen;
    idx = pc[9:4];
    tg  = pc[31:10];
    if (!(vm[idx] && tm[idx] == tg)) begin
      for (int k = 0; k < 4; k++) exp_addr.push_back({pc[31:4], 4'h0} + 32'(4 * k));
      vm[idx] = 1'b1;
      tm[idx] = tg;
    end
    exp_inst.push_back(mem_word({pc[31:2], 2'b00}));
    bus.in_fetcher_pc   = pc;
    bus.in_fetcher_flag = 1'b1;
    if (stall_at == 0) rdy = 1'b0;
    cycles = 0;
    seen   = 1'b0;
    while (!seen && cycles < 500) begin
      step();
      cycles++;
      if (bus.out_fetcher_flag) seen = 1'b1;
      else if (stall_at == -2) rdy = ($urandom_range(0, 3) != 0);
      else if (stall_at >= 0) begin
        if (cycles == stall_at) rdy = 1'b0;
        if (cycles == stall_at + 3) rdy = 1'b1;
      end
    end
    bus.in_fetcher_flag = 1'b0;
    rdy = 1'b1;
    check("fetch_done", 32'(seen), 32'd1);
    step();
  endtask

  // Start a miss, then flush (xbp) or reset once the nwords-th word request is up.
  task automatic fetch_abort(input logic [31:0] pc, input int nwords, input bit use_rst);
    logic [31:0] base;
    bit          found;
    int          n;
    base = {pc[31:4], 4'h0};
    for (int k = 0; k < nwords; k++) exp_addr.push_back(base + 32'(4 * k));
    if (use_rst) for (int i = 0; i < 64; i++) vm[i] = 1'b0;
    else vm[pc[9:4]] = 1'b0;
    bus.in_fetcher_pc   = pc;
    bus.in_fetcher_flag = 1'b1;
    found = 1'b0;
    n = 0;
    while (!found && n < 200) begin
      step();
      n++;
      if (bus.out_mem_flag && bus.out_mem_addr == base + 32'(4 * (nwords - 1))) found = 1'b1;
    end
    check("abort_reach", 32'(found), 32'd1);
    bus.in_fetcher_flag = 1'b0;
    if (use_rst) rst = 1'b1;
    else bus.in_rob_xbp = 1'b1;
    step();
    rst = 1'b0;
    bus.in_rob_xbp = 1'b0;
    check("abort_mem_flag", 32'(bus.out_mem_flag), 32'd0);
    check("abort_fetch_flag", 32'(bus.out_fetcher_flag), 32'd0);
    if (use_rst) begin
      check("rst_mem_addr", bus.out_mem_addr, 32'd0);
      check("rst_inst", bus.out_fetcher_inst, 32'd0);
    end
    repeat (8) step();
  endtask

  initial begin
    int c;
    logic [31:0] pc;
    int idx;
    rst = 1'b1;
    rdy = 1'b1;
    bus.in_fetcher_flag = 1'b0;
    bus.in_fetcher_pc   = '0;
    bus.in_rob_xbp      = 1'b0;
    for (int i = 0; i < 64; i++) vm[i] = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    check("reset_fetch_flag", 32'(bus.out_fetcher_flag), 32'd0);
    check("reset_inst", bus.out_fetcher_inst, 32'd0);
    check("reset_mem_flag", 32'(bus.out_mem_flag), 32'd0);
    check("reset_mem_addr", bus.out_mem_addr, 32'd0);
    step();

    fetch(32'h104, -1, c); check("cold_miss_latency", 32'(c), 32'd16);
    fetch(32'h10C, -1, c); check("hit_latency", 32'(c), 32'd1);
    fetch(32'h108, 0, c);  check("hit_stall_latency", 32'(c), 32'd4);
    fetch(32'h504, -1, c); check("conflict_latency", 32'(c), 32'd16);
    fetch(32'h104, -1, c); check("evict_miss_latency", 32'(c), 32'd16);
    fetch(32'h148, 6, c);  check("refill_stall_latency", 32'(c), 32'd19);

    fetch_abort(32'h200, 2, 1'b0);
    fetch(32'h200, -1, c); check("post_xbp_refill", 32'(c), 32'd16);

    fetch_abort(32'h600, 3, 1'b1);
    fetch(32'h104, -1, c); check("post_rst_refill", 32'(c), 32'd16);

    for (int t = 0; t < 150; t++) begin
      idx = $urandom_range(0, 8);
      if (idx == 8) idx = 16;
      pc = (32'($urandom_range(0, 3)) << 10) | (32'(idx) << 4)
         | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
      fetch(pc, ($urandom_range(0, 2) == 0) ? -2 : -1, c);
      if ($urandom_range(0, 7) == 0) begin
        bus.in_rob_xbp = 1'b1;
        step();
        bus.in_rob_xbp = 1'b0;
        step();
      end
    end

    repeat (10) step();
    check("resp_queue_drained", 32'(exp_inst.size()), 32'd0);
    check("addr_queue_drained", 32'(exp_addr.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, passed=%0d total=%0d", passes, checks);
    $fatal(1);
  end

endmodule

// File: doc/icache.md
Name: icache

Overview:
- Direct-mapped, read-only instruction cache between the fetcher and memCtrl.
- Absorbs the fetcher's word requests and returns hits one cycle after acceptance.
- On a miss, refills a 4-word line through memCtrl's fetcher port, one 32-bit word request at a time.
- Aborts any in-flight refill on in_rob_xbp (branch mispredict flush).

Parameters:
INDEX_BITS, 6, log2 of line count (64 lines).
LINE_WORDS_LOG, 2, log2 of words per line (4 words = 16 bytes); fixed at 2 for this revision.

Ports:
clk  in  1  clock; all logic on posedge.
rst  in  1  synchronous, active-high reset.
rdy  in  1  global ready; low freezes all state and outputs.
in_fetcher_flag  in  1  fetch request, held high until response.
in_fetcher_pc  in  32  fetch address; bits [1:0] ignored.
out_fetcher_flag  out  1  one-cycle response pulse.
out_fetcher_inst  out  32  instruction word, valid while out_fetcher_flag=1.
out_mem_flag  out  1  word read request to memCtrl, held until served.
out_mem_addr  out  32  word-aligned refill address.
in_mem_flag  in  1  one-cycle pulse; memCtrl word ready.
in_mem_data  in  32  word from memCtrl, valid with in_mem_flag.
in_rob_xbp  in  1  mispredict flush.

Behaviour:
- Address split:
  - word offset = pc[3:2]
  - index = pc[4+INDEX_BITS-1:4]
  - tag = pc[31:4+INDEX_BITS]
- Storage per line: valid bit, tag, 4 data words.
- Reset: all valid=0; state=IDLE; out_fetcher_flag=0; out_fetcher_inst=0; out_mem_flag=0; out_mem_addr=0; refill word counter=0.
  - Reset mid-refill discards the partial line; the line stays invalid.
- rdy=0: no state, array, or output changes. A pulse on in_mem_flag while rdy=0 is not seen; memCtrl is frozen by the same rdy.
- States: IDLE, REFILL, RESP.
- IDLE:
  - A request is accepted when in_fetcher_flag=1 and out_fetcher_flag=0; the PC is latched.
  - Hit (valid && tag match): next cycle out_fetcher_flag=1 and out_fetcher_inst=word[offset]; stay IDLE. Hit latency is 1 cycle.
  - Miss: next cycle enter REFILL with counter=0, out_mem_flag=1, out_mem_addr={pc[31:4],4'b0}; clear the line's valid bit.
- REFILL:
  - On in_mem_flag: write in_mem_data into word[counter].
  - If counter<3: counter+1, and out_mem_addr advances by 4. out_mem_flag is deasserted for exactly one cycle between words so memCtrl sees a fresh request.
  - If counter==3: set valid, write tag, drop out_mem_flag, go to RESP.
- RESP:
  - out_fetcher_flag=1 for one cycle; out_fetcher_inst = requested word, forwarded from the refilled line.
  - Return to IDLE.
- out_fetcher_flag is always a single-cycle pulse. The fetcher drops or changes its request in that cycle; the cache never accepts in a cycle where out_fetcher_flag=1.
- in_rob_xbp=1 (any state, rdy=1):
  - Next cycle: state=IDLE, out_mem_flag=0, out_fetcher_flag=0, counter=0.
  - An in_mem_flag in the same cycle is discarded.
  - The partially refilled line stays invalid; other lines are untouched.
  - A fetcher request in the xbp cycle is not accepted.
- in_mem_flag in IDLE or RESP is ignored.
- No writes from the data side; self-modifying code is not supported.
- Arithmetic:
  - Refill address = {latched_pc[31:4], counter, 2'b00}.
  - Counter is LINE_WORDS_LOG bits and does not wrap within a refill.

Test Plan:
- Cold miss: reset, then request pc=0x104; memCtrl returns 0x11,0x22,0x33,0x44 for 0x100..0x10C (latency 2 each) → out_mem_addr sequence 0x100,0x104,0x108,0x10C; a single out_fetcher_flag pulse with inst=0x22 one cycle after the 4th in_mem_flag.
- Hit: after the above, request 0x10C → out_fetcher_flag=1, inst=0x44 one cycle after acceptance; out_mem_flag stays 0.
- Conflict eviction:
  - Request 0x504 (index 16, tag 1) → full refill from 0x500.
  - Then 0x104 → miss again and refill from 0x100.
- Mispredict mid-refill: assert in_rob_xbp during the 2nd word of a 0x200 refill → next cycle out_mem_flag=0, no fetcher pulse; a later request to 0x200 misses and refills all 4 words.
- rdy stall: drop rdy for 3 cycles during REFILL and during a pending hit response → outputs and counter hold; completion is delayed exactly 3 cycles.
- Reset mid-refill: assert rst at the 3rd word → all outputs 0 next cycle; request 0x104 afterwards misses.
